mp3_stream_feeder: RTL and testbench
====================================

Name: mp3_stream_feeder

Overview:
- Supplies the compressed MP3 bitstream to the decoder's bitstream input port (`fifo_datain` / `fifo_ren`).
- Takes a byte stream with a valid/ready handshake from a host/loader and packs byte pairs big-endian into 16-bit words.
- Buffers the words in a show-ahead FIFO and presents them to the decoder.
- Handles end of stream: pads an odd trailing byte, reports drain, and flags reads from an empty buffer.

Parameters:
- DEPTH_LOG2, 4, log2 of word storage depth (memory holds 2**DEPTH_LOG2 words, plus 1 output register).
- PAD_BYTE, 8'h00, low byte used to complete an odd-length stream.
- PAD_WORD, 16'h0000, value driven on `fifo_datain` when no word is valid.

Ports:
- MASTER_CLOCK_I  in  1  single clock; all logic on its rising edge.
- global_rst_n  in  1  reset, synchronous, active-low.
- module_en  in  1  low = freeze: no byte accepted, no pop, all state held.
- byte_data  in  8  input stream byte, first byte of the file first.
- byte_valid  in  1  `byte_data` is valid.
- byte_last  in  1  qualifies the final byte of the stream (sampled with `byte_valid`).
- byte_ready  out  1  feeder accepts a byte this cycle.
- fifo_ren  in  1  decoder consumes the word currently on `fifo_datain`.
- fifo_datain  out  16  head word, show-ahead.
- fifo_empty  out  1  no valid head word.
- fifo_level  out  DEPTH_LOG2+1  words held (memory count + output register valid).
- stream_end  out  1  last byte accepted and every word consumed.
- underrun  out  1  sticky: `fifo_ren` seen while `fifo_empty` = 1.

Behaviour:
- Reset (`global_rst_n` = 0 at a clock edge), outputs and state:
  - `byte_ready` = 0, `fifo_datain` = PAD_WORD, `fifo_empty` = 1, `fifo_level` = 0, `stream_end` = 0, `underrun` = 0.
  - Pointers 0, packer in PK_HI, eos_seen = 0.
  - A mid-operation reset discards all buffered data and any held byte.
  - Memory contents need no reset.
- Byte acceptance: a byte is accepted at an edge where `byte_valid` & `byte_ready`.
- Packer FSM:
  - PK_HI:
    - `byte_ready` = `module_en` & ~eos_seen.
    - Accepted byte is latched as hi byte, then go to PK_LO.
    - If `byte_last` is set with it, go to PK_PAD and set eos_seen.
  - PK_LO:
    - `byte_ready` = `module_en` & ~mem_full.
    - On acceptance, push {hi, byte} into memory at the same edge.
    - Next state is PK_HI, or DONE if `byte_last` (set eos_seen).
  - PK_PAD:
    - `byte_ready` = 0.
    - At the first edge with `module_en` & ~mem_full, push {hi, PAD_BYTE}, then go to DONE.
  - DONE:
    - `byte_ready` = 0 until reset.
- mem_full: memory count == 2**DEPTH_LOG2. `fifo_level` maximum is 2**DEPTH_LOG2+1.
- Output stage (first-word fall-through):
  - Internal out_valid register; `fifo_empty` = ~out_valid; `fifo_datain` = out_valid ? out_reg : PAD_WORD.
  - If out_valid = 0 and memory is non-empty: load out_reg from the memory head, pop memory, out_valid <= 1.
  - If `fifo_ren` & out_valid & `module_en`:
    - Memory non-empty: load next head in the same edge (no bubble).
    - Memory empty: out_valid <= 0.
  - A word pushed into an empty memory at edge E becomes visible (`fifo_empty` = 0) after edge E+1.
  - Push and pop at the same edge are both honoured; the count is unchanged.
- `fifo_ren` while `fifo_empty`: ignored for data and pointers; `underrun` <= 1 (sticky until reset).
- `stream_end` <= 1 when: packer is in DONE, memory is empty, and out_valid = 0.
- `module_en` = 0: no push, no pop, no out_reg load, no change to `underrun`; `byte_ready` = 0.
- Pointers are DEPTH_LOG2 bits with natural wrap; the count is a separate DEPTH_LOG2+1-bit register.

Decomposition:
- Package mp3_feeder_pkg:
  - pk_state_t enum {PK_HI, PK_LO, PK_PAD, DONE}.
  - Default PAD_BYTE / PAD_WORD constants.
- Sub-module sync_fwft_fifo (memory, pointers, count, output register, empty/full):
  - Parameterised by width 16 and DEPTH_LOG2.
  - The top level holds the packer FSM, end-of-stream handling and the underrun flag.

Test Plan:
- Basic pack:
  - Stimulus: bytes 49,44,33,04 back-to-back, `fifo_ren` = 0.
  - Response: `fifo_datain` = 16'h4944 one edge after the 2nd byte is accepted; `fifo_level` = 2 after the 4th byte plus 1 edge.
  - Then: pulse `fifo_ren` → 16'h3304 on the next cycle; pulse again → `fifo_empty` = 1, `fifo_datain` = 16'h0000.
- Odd length:
  - Stimulus: bytes FF,FB,90 with `byte_last` on 90.
  - Response: words 16'hFFFB, 16'h9000; `byte_ready` stays 0 afterwards.
  - Then: after two reads, `stream_end` = 1 and `underrun` = 0.
- Backpressure (DEPTH_LOG2 = 4):
  - Stimulus: 40 bytes offered with no reads.
  - Response: 35 bytes accepted (17 words + 1 held hi byte), `byte_ready` = 0, `fifo_level` = 17.
  - Then: one read → 36th byte accepted; data order is intact.
- Streaming:
  - Stimulus: 256 incrementing bytes with `fifo_ren` asserted every cycle `fifo_empty` = 0.
  - Response: words 0001,0203,…,FEFF in order; no duplicates or drops; `underrun` = 0.
- Underrun and freeze:
  - Stimulus: `fifo_ren` while empty → `underrun` = 1 and held.
  - Stimulus: `module_en` = 0 with a full buffer and `fifo_ren` = 1 for 10 cycles → level and data unchanged.
- Reset mid-stream:
  - Stimulus: `global_rst_n` low for 1 edge after 7 bytes.
  - Response: all outputs at reset values; the next bytes AA,BB produce 16'hAABB.

Source files
------------

// File: rtl/mp3_stream_feeder_pkg.sv
// Shared types and default constants for the MP3 bitstream feeder.
package mp3_feeder_pkg;
  typedef enum logic [1:0] {PK_HI, PK_LO, PK_PAD, DONE} pk_state_t;

  localparam logic [7:0]  PAD_BYTE_DEF = 8'h00;
  localparam logic [15:0] PAD_WORD_DEF = 16'h0000;
endpackage

// File: rtl/mp3_stream_feeder_if.sv
// Byte-stream input and decoder-side word port of the feeder.
interface mp3_stream_feeder_if #(parameter int DEPTH_LOG2 = 4);
  logic [7:0]        byte_data;
  logic              byte_valid;
  logic              byte_last;
  logic              byte_ready;
  logic              fifo_ren;
  logic [15:0]       fifo_datain;
  logic              fifo_empty;
  logic [DEPTH_LOG2:0] fifo_level;
  logic              stream_end;
  logic              underrun;

  modport slave (
    input  byte_data, byte_valid, byte_last, fifo_ren,
    output byte_ready, fifo_datain, fifo_empty, fifo_level, stream_end, underrun
  );

  modport master (
    output byte_data, byte_valid, byte_last, fifo_ren,
    input  byte_ready, fifo_datain, fifo_empty, fifo_level, stream_end, underrun
  );
endinterface

// File: rtl/mp3_stream_feeder_fifo.sv
// Show-ahead FIFO: RAM of 2**DEPTH_LOG2 words plus one output register.
module sync_fwft_fifo #(
  parameter int              WIDTH      = 16,
  parameter int              DEPTH_LOG2 = 4,
  parameter logic [WIDTH-1:0] PAD_WORD  = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic [WIDTH-1:0]      dout,
  output logic                  empty,
  output logic                  full,
  output logic                  mem_empty,
  output logic [DEPTH_LOG2:0]   level
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [DEPTH_LOG2:0]   count;
  logic [WIDTH-1:0]      out_reg;
  logic                  out_valid;
  logic                  do_push, do_rd, do_pop;

  assign mem_empty = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign do_push   = en & push & ~full;
  assign do_rd     = en & pop & out_valid;
  // RAM head moves into the output register whenever that register is free or being consumed
  assign do_pop    = en & ~mem_empty & (~out_valid | do_rd);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      out_reg   <= '0;
      out_valid <= 1'b0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) begin
        out_reg   <= mem[rptr];
        rptr      <= rptr + 1'b1;
        out_valid <= 1'b1;
      end else if (do_rd) begin
        out_valid <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

  assign dout  = out_valid ? out_reg : PAD_WORD;
  assign empty = ~out_valid;
  assign level = count + (DEPTH_LOG2+1)'(out_valid);
endmodule

// File: rtl/mp3_stream_feeder.sv
// Packs a byte stream big-endian into 16-bit words and feeds the decoder FIFO port.
module mp3_stream_feeder
  import mp3_feeder_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  PAD_BYTE   = PAD_BYTE_DEF,
  parameter logic [15:0] PAD_WORD   = PAD_WORD_DEF
) (
  input  logic MASTER_CLOCK_I,
  input  logic global_rst_n,
  input  logic module_en,
  mp3_stream_feeder_if.slave bus
);
  pk_state_t   state, state_nx;
  logic [7:0]  hi;
  logic        eos_seen;
  logic        ready, accept, push;
  logic [15:0] push_data;
  logic        mem_full, mem_empty, out_empty;
  logic        underrun, stream_end;

  always_comb begin
    state_nx  = state;
    ready     = 1'b0;
    push      = 1'b0;
    push_data = {hi, bus.byte_data};
    case (state)
      PK_HI:  ready = module_en & ~eos_seen;
      PK_LO:  ready = module_en & ~mem_full;
      default: ready = 1'b0;
    endcase
    ready  = ready & global_rst_n;
    accept = bus.byte_valid & ready;
    case (state)
      PK_HI: if (accept) state_nx = bus.byte_last ? PK_PAD : PK_LO;
      PK_LO: if (accept) begin
        push     = 1'b1;
        state_nx = bus.byte_last ? DONE : PK_HI;
      end
      PK_PAD: begin
        push_data = {hi, PAD_BYTE};
        if (module_en & ~mem_full) begin
          push     = 1'b1;
          state_nx = DONE;
        end
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge MASTER_CLOCK_I) begin
    if (!global_rst_n) begin
      state      <= PK_HI;
      hi         <= '0;
      eos_seen   <= 1'b0;
      underrun   <= 1'b0;
      stream_end <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && state == PK_HI) hi <= bus.byte_data;
      if (accept && bus.byte_last) eos_seen <= 1'b1;
      if (module_en && bus.fifo_ren && out_empty) underrun <= 1'b1;
      if (state == DONE && mem_empty && out_empty) stream_end <= 1'b1;
    end
  end

  sync_fwft_fifo #(
    .WIDTH(16), .DEPTH_LOG2(DEPTH_LOG2), .PAD_WORD(PAD_WORD)
  ) u_fifo (
    .clk       (MASTER_CLOCK_I),
    .rst_n     (global_rst_n),
    .en        (module_en),
    .push      (push),
    .push_data (push_data),
    .pop       (bus.fifo_ren),
    .dout      (bus.fifo_datain),
    .empty     (out_empty),
    .full      (mem_full),
    .mem_empty (mem_empty),
    .level     (bus.fifo_level)
  );

  assign bus.byte_ready = ready;
  assign bus.fifo_empty = out_empty;
  assign bus.underrun   = underrun;
  assign bus.stream_end = stream_end;
endmodule

// File: tb/tb_mp3_stream_feeder.sv
// Scoreboarded bench for mp3_stream_feeder: directed byte streams, words checked on consumption.
module tb_mp3_stream_feeder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b1;
  always #5 clk = ~clk;

  mp3_stream_feeder_if #(.DEPTH_LOG2(4)) bus();

  mp3_stream_feeder #(.DEPTH_LOG2(4), .PAD_BYTE(8'h00), .PAD_WORD(16'h0000)) dut (
    .MASTER_CLOCK_I (clk),
    .global_rst_n   (rst_n),
    .module_en      (en),
    .bus            (bus)
  );

  int n_pass = 0;
  int n_tot  = 0;
  logic [15:0] exp_q [$];
  bit sdone;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: every word the decoder consumes must match the scoreboard head
  always @(negedge clk) begin
    if (rst_n && en && bus.fifo_ren && !bus.fifo_empty) begin
      if (exp_q.size() == 0) begin
        n_tot++;
        $display("FAIL unexpected_word: got %h expected none", bus.fifo_datain);
      end else begin
        check("word", {16'h0, bus.fifo_datain}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    check("rst_byte_ready", bus.byte_ready, 0);
    check("rst_datain",     bus.fifo_datain, 16'h0000);
    check("rst_empty",      bus.fifo_empty, 1);
    check("rst_level",      bus.fifo_level, 0);
    check("rst_stream_end", bus.stream_end, 0);
    check("rst_underrun",   bus.underrun, 0);
    rst_n = 1'b1;
  endtask

  task automatic try_send(input logic [7:0] b, input bit last, input int bound, output bit acc);
    acc = 1'b0;
    bus.byte_data = b; bus.byte_last = last; bus.byte_valid = 1'b1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (bus.byte_ready) begin acc = 1'b1; break; end
    end
    tick();
    bus.byte_valid = 1'b0; bus.byte_last = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit last);
    bit acc;
    try_send(b, last, 200, acc);
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      bus.fifo_ren = !bus.fifo_empty;
      tick();
      n++;
    end
    bus.fifo_ren = 1'b0;
    check("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    int acc_cnt;
    bit acc;
    bus.byte_data = '0; bus.byte_valid = 1'b0; bus.byte_last = 1'b0; bus.fifo_ren = 1'b0;
    do_reset();

    // basic pack and show-ahead latency
    exp_q.push_back(16'h4944); exp_q.push_back(16'h3304);
    send(8'h49, 0); send(8'h44, 0);
    check("t1_not_visible_yet", bus.fifo_empty, 1);
    send(8'h33, 0);
    check("t1_first_word", bus.fifo_datain, 16'h4944);
    send(8'h04, 0);
    tick();
    check("t1_level", bus.fifo_level, 2);
    bus.fifo_ren = 1'b1; tick(); bus.fifo_ren = 1'b0;
    check("t1_second_word", bus.fifo_datain, 16'h3304);
    bus.fifo_ren = 1'b1; tick(); bus.fifo_ren = 1'b0;
    check("t1_empty", bus.fifo_empty, 1);
    check("t1_pad_word", bus.fifo_datain, 16'h0000);

    // odd length with padding
    exp_q.push_back(16'hFFFB); exp_q.push_back(16'h9000);
    send(8'hFF, 0); send(8'hFB, 0); send(8'h90, 1);
    repeat (3) tick();
    check("t2_ready_low", bus.byte_ready, 0);
    check("t2_level", bus.fifo_level, 2);
    check("t2_no_end_yet", bus.stream_end, 0);
    drain();
    tick(); tick();
    check("t2_stream_end", bus.stream_end, 1);
    check("t2_underrun", bus.underrun, 0);
    check("t2_ready_after", bus.byte_ready, 0);

    // backpressure
    do_reset();
    for (int k = 0; k < 17; k++) exp_q.push_back({8'(2*k), 8'(2*k+1)});
    acc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      try_send(8'(i), 0, 3, acc);
      if (acc) acc_cnt++;
    end
    check("t3_accepted", acc_cnt, 35);
    check("t3_ready_low", bus.byte_ready, 0);
    check("t3_level", bus.fifo_level, 17);
    bus.fifo_ren = 1'b1; tick(); bus.fifo_ren = 1'b0;
    exp_q.push_back(16'h2223);
    try_send(8'd35, 0, 3, acc);
    check("t3_36th_accepted", acc, 1);
    drain();

    // streaming with continuous reads
    do_reset();
    sdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 256; i += 2) begin
          exp_q.push_back({8'(i), 8'(i+1)});
          send(8'(i), 0);
          send(8'(i+1), 0);
        end
        sdone = 1'b1;
      end
      begin
        int n = 0;
        while (!(sdone && exp_q.size() == 0) && n < 3000) begin
          bus.fifo_ren = !bus.fifo_empty;
          tick();
          n++;
        end
        bus.fifo_ren = 1'b0;
      end
    join
    check("t4_all_consumed", exp_q.size(), 0);
    check("t4_underrun", bus.underrun, 0);

    // underrun, then freeze with a full buffer
    tick();
    bus.fifo_ren = 1'b1; tick(); bus.fifo_ren = 1'b0;
    check("t5_underrun_set", bus.underrun, 1);
    repeat (2) tick();
    check("t5_underrun_held", bus.underrun, 1);
    for (int k = 0; k < 17; k++) exp_q.push_back({8'(8'h80 + 2*k), 8'(8'h81 + 2*k)});
    for (int i = 0; i < 34; i++) send(8'(8'h80 + i), 0);
    tick();
    check("t5_full_level", bus.fifo_level, 17);
    en = 1'b0; bus.fifo_ren = 1'b1;
    repeat (10) tick();
    check("t5_frozen_level", bus.fifo_level, 17);
    check("t5_frozen_data", bus.fifo_datain, 16'h8081);
    check("t5_frozen_ready", bus.byte_ready, 0);
    bus.fifo_ren = 1'b0; en = 1'b1;
    drain();

    // reset mid-stream discards everything
    for (int i = 0; i < 7; i++) send(8'(8'h11 + i), 0);
    tick();
    do_reset();
    exp_q.push_back(16'hAABB);
    send(8'hAA, 0); send(8'hBB, 0);
    drain();
    tick();
    check("t6_empty_after", bus.fifo_empty, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
